// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU load/store sequencer.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    LAST = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam int LSU_RAM_SIZE = 32768;

endpackage

// File: rtl/lsu_addr_chk.sv
// Combinational range check for a byte or halfword request.
// A halfword is rejected if either of its two bytes falls outside the RAM,
// with the high-byte address wrapping modulo 2^AW.
module lsu_addr_chk
  import lsu_pkg::*;
#(
  parameter int AW       = 16,
  parameter int RAM_SIZE = LSU_RAM_SIZE
) (
  input  logic [AW-1:0] addr,
  input  logic          size,
  output logic          err
);

  localparam logic [AW:0] LIMIT = (AW+1)'(RAM_SIZE);

  logic [AW-1:0] addr_hi;

  // Flag the low byte, and the high byte for halfwords.
  always_comb begin
    addr_hi = addr + 1'b1;
    err     = ({1'b0, addr} >= LIMIT);
    if ((size == SZ_HALF) && ({1'b0, addr_hi} >= LIMIT)) err = 1'b1;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of the byte-wide LSU data RAM.
// Splits halfwords into two little-endian byte accesses, collects read data
// and returns one response per request.
// Build option LSU_SIGN_EXT_EN adds req_signed for sign-extended byte loads.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW       = 16,
  parameter int RAM_SIZE = LSU_RAM_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
`ifdef LSU_SIGN_EXT_EN
  input  logic          req_signed,
`endif
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [7:0]    ram_d,
  output logic [AW-1:0] ram_a,
  output logic          ram_re,
  output logic          ram_we,
  input  logic [7:0]    ram_q
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic          size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          req_err, req_sgn, accept;

  lsu_addr_chk #(.AW(AW), .RAM_SIZE(RAM_SIZE)) u_chk (
    .addr (req_addr),
    .size (req_size),
    .err  (req_err)
  );

`ifdef LSU_SIGN_EXT_EN
  assign req_sgn = req_signed;
`else
  assign req_sgn = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Sequencer next-state: latch request, walk byte accesses, hold response.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = req_we;
        size_d  = req_size;
        sgn_d   = req_sgn;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = 16'h0000;
        err_d   = req_err;
        if (req_err) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ACC0;
        end
      end
      ACC0: begin
        if (size_q == SZ_HALF) state_d = ACC1;
        else if (!we_q)        state_d = LAST;
        else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end
      end
      ACC1: begin
        if (!we_q) begin
          rdata_d[7:0] = ram_q;
          state_d      = LAST;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end
      end
      LAST: begin
        if (size_q == SZ_HALF) rdata_d[15:8] = ram_q;
        else rdata_d = {(sgn_q && ram_q[7]) ? 8'hFF : 8'h00, ram_q};
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive: active only in the two access states, silenced during reset.
  always_comb begin
    ram_a  = '0;
    ram_d  = 8'h00;
    ram_re = 1'b0;
    ram_we = 1'b0;
    if (!rst) begin
      case (state_q)
        ACC0: begin
          ram_a  = addr_q;
          ram_d  = wdata_q[7:0];
          ram_re = !we_q;
          ram_we = we_q;
        end
        ACC1: begin
          ram_a  = addr_q + 1'b1;
          ram_d  = wdata_q[15:8];
          ram_re = !we_q;
          ram_we = we_q;
        end
        default: ;
      endcase
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural byte RAM.
// Define LSU_SIGN_EXT_EN for the sign-extension build.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_size;
  logic [15:0] req_addr, req_wdata;
  logic        req_signed;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  ram_d, ram_q;
  logic [15:0] ram_a;
  logic        ram_re, ram_we;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  bit [7:0] mem [0:65535];

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(16), .RAM_SIZE(32768)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef LSU_SIGN_EXT_EN
    .req_signed(req_signed),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_d     (ram_d),
    .ram_a     (ram_a),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  // Behavioural RAM: q valid the cycle after re.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    if (ram_re) ram_q <= mem[ram_a];
  end

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (ram_re) re_cnt++;
  end

  typedef struct {
    logic        we;
    logic        size;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        sgn;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input int hold, input string nm);
    int lat, waitc;
    logic [15:0] rd0;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_addr = v.addr;
    req_wdata = v.wdata; req_signed = v.sgn; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    waitc = 0;
    while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!req_ready) begin
      chk({nm, " ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    we_cnt = 0; re_cnt = 0;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({nm, " err"}, rsp_err, v.exp_err);
    chk({nm, " we_pulses"}, we_cnt, v.exp_we);
    chk({nm, " re_pulses"}, re_cnt, v.exp_re);
    rd0 = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold_valid"}, rsp_valid, 1);
      chk({nm, " hold_rdata"}, rsp_rdata, rd0);
      chk({nm, " hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, " rsp_done"}, rsp_valid, 0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0; req_signed = 1'b0; rsp_ready = 1'b1;

    //          we    sz    addr      wdata     sgn   rdata     err   lat we re
    tbl.push_back('{1'b1, 1'b0, 16'h0010, 16'h00A5, 1'b0, 16'h0000, 1'b0, 2, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00A5, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 3, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h00EF, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 16'h0101, 16'h0000, 1'b0, 16'h00BE, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4, 0, 2});
    tbl.push_back('{1'b1, 1'b0, 16'h7FFF, 16'h005A, 1'b0, 16'h0000, 1'b0, 2, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 16'h7FFE, 16'h0011, 1'b0, 16'h0000, 1'b0, 2, 1, 0});
    tbl.push_back('{1'b1, 1'b1, 16'h7FFF, 16'h1234, 1'b0, 16'h0000, 1'b1, 1, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 16'h8000, 16'h5678, 1'b0, 16'h0000, 1'b1, 1, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 16'h005A, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 16'h7FFE, 16'h0000, 1'b0, 16'h5A11, 1'b0, 4, 0, 2});
    tbl.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 16'h0200, 16'h3C77, 1'b0, 16'h0000, 1'b0, 2, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0077, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0077, 1'b0, 4, 0, 2});
    tbl.push_back('{1'b1, 1'b0, 16'h0020, 16'h0080, 1'b0, 16'h0000, 1'b0, 2, 1, 0});
`ifdef LSU_SIGN_EXT_EN
    tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'hFF80, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0080, 1'b0, 3, 0, 1});
    tbl.push_back('{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 4, 0, 2});
`else
    tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0080, 1'b0, 3, 0, 1});
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst ram_re", ram_re, 0);
    chk("rst ram_we", ram_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", req_ready, 1);

    foreach (tbl[i]) txn(tbl[i], 0, $sformatf("v%0d", i));

    // Backpressure: response held five cycles.
    v = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4, 0, 2};
    txn(v, 5, "bp");

    // Reset during ACC1 of a halfword load.
    @(negedge clk);
    req_we = 1'b0; req_size = 1'b1; req_addr = 16'h0100; req_signed = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    chk("mr ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mr acc0_re", ram_re, 1);
    chk("mr acc0_a", ram_a, 16'h0100);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("mr gated_re", ram_re, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr rsp_valid", rsp_valid, 0);
    chk("mr ram_re", ram_re, 0);
    chk("mr req_ready", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("mr no_rsp", rsp_valid, 0);
    end
    v = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4, 0, 2};
    txn(v, 0, "mr_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
